// File: rtl/mem_window_reader_pkg.sv
// Shared definitions for the 2-D window read sequencer: state encoding and
// default widths.
package mem_window_reader_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_DRAIN  = 2'd2;
  localparam state_t ST_FINISH = 2'd3;
endpackage

// File: rtl/mem_window_addr_gen.sv
// Column/row walker for the read window. It holds the latched window
// geometry and steps the current byte address on each advance strobe.
module mem_window_addr_gen
  import mem_window_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  row_len_i,
  input  logic [LEN_W-1:0]  num_rows_i,
  input  logic [ADDR_W-1:0] row_stride_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] cur_addr_o,
  output logic              last_o
);
  logic [LEN_W-1:0]  row_len_q, row_len_d, num_rows_q, num_rows_d;
  logic [LEN_W-1:0]  col_q, col_d, row_q, row_d;
  logic [ADDR_W-1:0] stride_q, stride_d, row_base_q, row_base_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              row_end;

  assign row_end    = (col_q == row_len_q - LEN_W'(1));
  assign last_o     = row_end && (row_q == num_rows_q - LEN_W'(1));
  assign cur_addr_o = cur_addr_q;

  always_comb begin
    row_len_d  = row_len_q;
    num_rows_d = num_rows_q;
    stride_d   = stride_q;
    row_base_d = row_base_q;
    cur_addr_d = cur_addr_q;
    col_d      = col_q;
    row_d      = row_q;
    if (load_i) begin
      row_len_d  = row_len_i;
      num_rows_d = num_rows_i;
      stride_d   = row_stride_i;
      row_base_d = base_addr_i;
      cur_addr_d = base_addr_i;
      col_d      = '0;
      row_d      = '0;
    end else if (adv_i) begin
      if (row_end) begin
        // Next row starts one stride past the previous row start, not past cur_addr.
        col_d      = '0;
        row_d      = row_q + LEN_W'(1);
        row_base_d = row_base_q + stride_q;
        cur_addr_d = row_base_q + stride_q;
      end else begin
        col_d      = col_q + LEN_W'(1);
        cur_addr_d = cur_addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_len_q  <= '0;
      num_rows_q <= '0;
      stride_q   <= '0;
      row_base_q <= '0;
      cur_addr_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      row_len_q  <= row_len_d;
      num_rows_q <= num_rows_d;
      stride_q   <= stride_d;
      row_base_q <= row_base_d;
      cur_addr_q <= cur_addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
  end
endmodule

// File: rtl/mem_window_reader.sv
// Streams a num_rows x row_len byte window out of the scratch memory over a
// valid/ready link, one byte per cycle when the consumer keeps up.
module mem_window_reader
  import mem_window_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  row_len,
  input  logic [LEN_W-1:0]  num_rows,
  input  logic [ADDR_W-1:0] row_stride,
  output logic              mem_rEn,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q, out_last_q;
  logic [ADDR_W-1:0] addr_hold_q, cur_addr;
  logic              load, issue, elem_last;

  assign load = (state_q == ST_IDLE) && start;

  mem_window_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_agen (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .base_addr_i  (base_addr),
    .row_len_i    (row_len),
    .num_rows_i   (num_rows),
    .row_stride_i (row_stride),
    .adv_i        (issue),
    .cur_addr_o   (cur_addr),
    .last_o       (elem_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = (row_len == '0 || num_rows == '0) ? ST_FINISH : ST_RUN;
      ST_RUN:    if (issue && elem_last) state_d = ST_DRAIN;
      ST_DRAIN:  if (out_valid_q && out_ready && out_last_q) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // A read only issues when the output register is free or emptying this cycle.
  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_FINISH);
    issue    = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    mem_rEn  = issue;
    mem_addr = issue ? cur_addr : addr_hold_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      addr_hold_q <= '0;
    end else if (issue) begin
      out_data_q  <= mem_data;
      out_valid_q <= 1'b1;
      out_last_q  <= elem_last;
      addr_hold_q <= cur_addr;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
endmodule

// File: tb/tb_mem_window_reader.sv
// Directed bench for mem_window_reader with a small big-endian byte memory.
module tb_mem_window_reader;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [31:0] base_addr = '0, row_stride = '0, mem_addr;
  logic [15:0] row_len = '0, num_rows = '0;
  logic        mem_rEn, out_valid, out_last, busy, done;
  logic [7:0]  mem_data, out_data;
  logic [31:0] words [3];
  int nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  mem_window_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_len(row_len),
    .num_rows(num_rows), .row_stride(row_stride), .mem_rEn(mem_rEn), .mem_addr(mem_addr),
    .mem_data(mem_data), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = (a[31:2] < 30'd3) ? words[a[3:2]] : 32'h0;
    return w[31 - 8*a[1:0] -: 8];
  endfunction

  assign mem_data = mem_rEn ? byte_at(mem_addr) : 8'hzz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one cycle; returns at the first RUN-cycle negedge.
  task automatic kick(input logic [31:0] b, input logic [15:0] l, input logic [15:0] r,
                      input logic [31:0] s);
    @(negedge clk);
    start = 1'b1; base_addr = b; row_len = l; num_rows = r; row_stride = s;
    #1 chk("idle_busy", busy, 1'b0);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Follows a 4-byte window through to done; bp selects the 1,0,0,1 ready
  // pattern, inj is the cycle at which a stray start (base 8) is pulsed.
  task automatic stream(input logic [7:0] eb [4], input logic [31:0] ea [4], input bit bp,
                        input int inj);
    logic [3:0] pat;
    logic [7:0] prev;
    bit stalled;
    int c, k, j, dn;
    pat = 4'b1001; c = 0; k = 0; j = 0; dn = 0; stalled = 0; prev = '0;
    while (k < 4 && c < 40) begin
      out_ready = bp ? pat[3 - (c % 4)] : 1'b1;
      start = (c == inj);
      if (c == inj) base_addr = 32'd8;
      #1;
      if (done) dn++;
      if (c == 0) chk("lat_c0_valid", out_valid, 1'b0);
      if (c == 1) chk("lat_c1_valid", out_valid, 1'b1);
      if (out_valid && !out_ready) chk("stall_ren", mem_rEn, 1'b0);
      if (stalled) chk("stall_data", out_data, prev);
      if (mem_rEn) begin
        chk("addr", mem_addr, ea[j]);
        j++;
      end
      if (out_valid && out_ready) begin
        chk("data", out_data, eb[k]);
        chk("last", out_last, k == 3);
        if (!bp) chk("thru", c, k + 1);
        k++;
      end
      stalled = out_valid && !out_ready;
      prev = out_data;
      c++;
      @(negedge clk);
    end
    start = 1'b0; out_ready = 1'b1;
    chk("beats", k, 4);
    #1;
    chk("done_pulse", done, 1'b1);
    chk("early_done", dn, 0);
    chk("reads", j, 4);
    @(negedge clk);
    #1;
    chk("done_drop", done, 1'b0);
    chk("busy_drop", busy, 1'b0);
  endtask

  logic [7:0]  b_basic [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [31:0] a_basic [4] = '{32'd0, 32'd1, 32'd2, 32'd3};
  logic [7:0]  b_2d    [4] = '{8'h22, 8'h33, 8'hAA, 8'hBB};
  logic [31:0] a_2d    [4] = '{32'd1, 32'd2, 32'd9, 32'd10};

  initial begin
    words[0] = 32'h11223344; words[1] = 32'h55667788; words[2] = 32'h99AABBCC;
    #2;
    chk("rst_ren", mem_rEn, 1'b0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk); rst = 1'b0;

    kick(32'd0, 16'd4, 16'd1, 32'd0);
    stream(b_basic, a_basic, 1'b0, -1);

    kick(32'd1, 16'd2, 16'd2, 32'd8);
    stream(b_2d, a_2d, 1'b0, -1);

    kick(32'd0, 16'd4, 16'd1, 32'd0);
    stream(b_basic, a_basic, 1'b1, -1);

    // Zero-length window: straight to FINISH with no reads.
    kick(32'd0, 16'd0, 16'd3, 32'd0);
    #1;
    chk("zl_ren", mem_rEn, 1'b0);
    chk("zl_valid", out_valid, 1'b0);
    chk("zl_done", done, 1'b1);
    @(negedge clk); #1;
    chk("zl_done_drop", done, 1'b0);
    chk("zl_ren2", mem_rEn, 1'b0);
    chk("zl_valid2", out_valid, 1'b0);

    kick(32'd0, 16'd4, 16'd1, 32'd0);
    stream(b_basic, a_basic, 1'b0, 2);

    // Abort after the second byte is presented.
    kick(32'd0, 16'd4, 16'd1, 32'd0);
    out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1 chk("pre_rst_data", out_data, 8'h22);
    rst = 1'b1;
    #1;
    chk("ar_ren", mem_rEn, 1'b0);
    chk("ar_addr", mem_addr, 32'd0);
    chk("ar_data", out_data, 8'h00);
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_last", out_last, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_done", done, 1'b0);
    @(negedge clk); #1 chk("ar_done2", done, 1'b0);
    @(negedge clk); rst = 1'b0;
    #1 chk("ar_done3", done, 1'b0);
    kick(32'd0, 16'd4, 16'd1, 32'd0);
    stream(b_basic, a_basic, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
